// File: rtl/tmds_video_sequencer_if.sv
// Pixel stream between the upstream char renderer and the video sequencer.
//   pix_valid : upstream has a pixel available
//   pix_data  : {R[23:16], G[15:8], B[7:0]}
//   pix_ready : sequencer consumes the pixel this cycle (combinational)
// master = pixel source (renderer), slave = sequencer.
interface tmds_video_sequencer_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/tmds_video_sequencer.sv
// Video timing/sequencing controller for the DVI output path.
// Scans an h/v raster, pulls pixels over the slave pixel stream while the raster
// is in the visible area, and drives registered data_en, hsync/vsync and RGB to
// the three TMDS encoders. Start/stop only take effect at frame boundaries.
// Ports:
//   i_clk, i_rst_n         pixel clock, async active-low reset
//   i_enable               run request (stop honoured at end of frame)
//   pix                    pixel stream (slave modport)
//   o_data_en              video data enable for all encoders
//   o_ctrl_0 / o_ctrl_1    hsync / vsync to the blue encoder
//   o_red/o_green/o_blue   8-bit colour to the encoders
//   o_frame_start          pulse aligned with the first output pixel of a frame
//   o_underflow            sticky flag: a visible pixel was not available
//   i_underflow_clr        clears o_underflow (a new underflow wins)
module tmds_video_sequencer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = 12
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    tmds_video_sequencer_if.slave        pix,
    output logic                         o_data_en,
    output logic                         o_ctrl_0,
    output logic                         o_ctrl_1,
    output logic [7:0]                   o_red,
    output logic [7:0]                   o_green,
    output logic [7:0]                   o_blue,
    output logic                         o_frame_start,
    output logic                         o_underflow,
    input  logic                         i_underflow_clr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    logic          data_en_q, data_en_d;
    logic          ctrl_0_q, ctrl_0_d;
    logic          ctrl_1_q, ctrl_1_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;

    logic          running_c;
    logic          frame_end_c;
    logic          active_c;

    assign running_c   = (state_q != ST_IDLE);
    assign frame_end_c = (h_q == H_LAST) && (v_q == V_LAST);
    assign active_c    = running_c && (h_q < H_ACT) && (v_q < V_ACT);

    assign pix.pix_ready = active_c;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and raster position; IDLE pins the counters at (0,0)
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        case (state_q)
            ST_IDLE:  if (i_enable) state_d = ST_RUN;
            ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (i_enable)         state_d = ST_RUN;
                else if (frame_end_c) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (running_c) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end else begin
            h_d = '0;
            v_d = '0;
        end
    end

    // Next values of the registered video outputs
    always_comb begin
        data_en_d     = active_c;
        rgb_d         = (active_c && pix.pix_valid) ? pix.pix_data : 24'h0;
        ctrl_0_d      = (running_c && (h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        ctrl_1_d      = (running_c && (v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = running_c && (h_q == '0) && (v_q == '0);
        underflow_d   = underflow_q;
        if (active_c && !pix.pix_valid) begin
            underflow_d = 1'b1;
        end else if (i_underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            data_en_q     <= 1'b0;
            ctrl_0_q      <= ~SYNC_POL;
            ctrl_1_q      <= ~SYNC_POL;
            rgb_q         <= 24'h0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            data_en_q     <= data_en_d;
            ctrl_0_q      <= ctrl_0_d;
            ctrl_1_q      <= ctrl_1_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign o_data_en     = data_en_q;
    assign o_ctrl_0      = ctrl_0_q;
    assign o_ctrl_1      = ctrl_1_q;
    assign o_red         = rgb_q[23:16];
    assign o_green       = rgb_q[15:8];
    assign o_blue        = rgb_q[7:0];
    assign o_frame_start = frame_start_q;
    assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Directed bench for tmds_video_sequencer on a tiny raster:
// H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), active-low syncs.
// Position p = k % 48 with h = p % 8, v = p / 8; registered outputs seen in
// cycle k describe position k-1.
module tb_tmds_video_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        data_en, ctrl_0, ctrl_1, frame_start, underflow;
    logic [7:0]  red, green, blue;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    localparam logic [23:0] PIX = 24'h112233;

    tmds_video_sequencer_if pix_if ();

    tmds_video_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .CW(4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .pix             (pix_if),
        .o_data_en       (data_en),
        .o_ctrl_0        (ctrl_0),
        .o_ctrl_1        (ctrl_1),
        .o_red           (red),
        .o_green         (green),
        .o_blue          (blue),
        .o_frame_start   (frame_start),
        .o_underflow     (underflow),
        .i_underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    function automatic logic act(input int p);
        return ((p % 8) < 4) && ((p / 8) < 3);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k = k + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data = 24'h0;
        underflow_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({ctrl_0, ctrl_1} !== 2'b11) begin n_err++; $display("FAIL reset_sync got %b want 11", {ctrl_0, ctrl_1}); end
        n_cmp++; if (data_en !== 1'b0) begin n_err++; $display("FAIL reset_data_en got %b want 0", data_en); end
        n_cmp++; if ({red, green, blue} !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %h want 000000", {red, green, blue}); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b want 0", underflow); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", pix_if.pix_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({pix_if.pix_ready, data_en, ctrl_0, ctrl_1} !== 4'b0011) begin
                n_err++; $display("FAIL idle_outputs got %b want 0011", {pix_if.pix_ready, data_en, ctrl_0, ctrl_1});
            end
        end
    endtask

    task automatic test_stream();
        int q;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data = PIX;
        enable = 1'b1;
        step();
        k = 0;
        while (k < 96) begin
            n_cmp++; if (pix_if.pix_ready !== act(k % 48)) begin
                n_err++; $display("FAIL stream_ready k=%0d got %b want %b", k, pix_if.pix_ready, act(k % 48));
            end
            if (k > 0) begin
                q = (k - 1) % 48;
                n_cmp++; if (data_en !== act(q)) begin
                    n_err++; $display("FAIL stream_data_en k=%0d got %b want %b", k, data_en, act(q));
                end
                n_cmp++; if ({red, green, blue} !== (act(q) ? PIX : 24'h0)) begin
                    n_err++; $display("FAIL stream_rgb k=%0d got %h want %h", k, {red, green, blue}, act(q) ? PIX : 24'h0);
                end
                n_cmp++; if (ctrl_0 !== !((q % 8) == 5 || (q % 8) == 6)) begin
                    n_err++; $display("FAIL stream_hsync k=%0d got %b", k, ctrl_0);
                end
                n_cmp++; if (ctrl_1 !== !((q / 8) == 4)) begin
                    n_err++; $display("FAIL stream_vsync k=%0d got %b", k, ctrl_1);
                end
                n_cmp++; if (frame_start !== (q == 0)) begin
                    n_err++; $display("FAIL stream_frame_start k=%0d got %b want %b", k, frame_start, q == 0);
                end
                n_cmp++; if (underflow !== 1'b0) begin
                    n_err++; $display("FAIL stream_underflow k=%0d got %b want 0", k, underflow);
                end
            end
            step();
        end
    endtask

    task automatic test_underflow();
        while (k % 48 != 10) step();
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_err++; $display("FAIL uf_ready got %b want 1", pix_if.pix_ready); end
        pix_if.pix_valid = 1'b0;
        step();
        pix_if.pix_valid = 1'b1;
        n_cmp++; if ({red, green, blue} !== 24'h0) begin n_err++; $display("FAIL uf_rgb got %h want 000000", {red, green, blue}); end
        n_cmp++; if (data_en !== 1'b1) begin n_err++; $display("FAIL uf_data_en got %b want 1", data_en); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", underflow); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky i=%0d got %b want 1", i, underflow); end
        end
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear got %b want 0", underflow); end
        while (k % 48 != 16) step();
        pix_if.pix_valid = 1'b0;
        underflow_clr = 1'b1;
        step();
        pix_if.pix_valid = 1'b1;
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_wins got %b want 1", underflow); end
        n_cmp++; if ({red, green, blue} !== 24'h0) begin n_err++; $display("FAIL uf_rgb2 got %h want 000000", {red, green, blue}); end
        step();
        underflow_clr = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear2 got %b want 0", underflow); end
    endtask

    task automatic test_stop();
        int q;
        while (k % 48 != 19) step();
        enable = 1'b0;
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_err++; $display("FAIL stop_ready got %b want 1", pix_if.pix_ready); end
        step();
        while (k % 48 != 0) begin
            q = (k - 1) % 48;
            n_cmp++; if (data_en !== act(q)) begin n_err++; $display("FAIL drain_data_en k=%0d got %b", k, data_en); end
            n_cmp++; if (ctrl_1 !== !((q / 8) == 4)) begin n_err++; $display("FAIL drain_vsync k=%0d got %b", k, ctrl_1); end
            n_cmp++; if (ctrl_0 !== !((q % 8) == 5 || (q % 8) == 6)) begin n_err++; $display("FAIL drain_hsync k=%0d got %b", k, ctrl_0); end
            step();
        end
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL stop_idle_ready got %b want 0", pix_if.pix_ready); end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++; if ({pix_if.pix_ready, data_en, ctrl_0, ctrl_1, frame_start} !== 5'b00110) begin
                n_err++; $display("FAIL stop_idle i=%0d got %b want 00110", i, {pix_if.pix_ready, data_en, ctrl_0, ctrl_1, frame_start});
            end
        end
    endtask

    task automatic test_back_to_back();
        enable = 1'b1;
        step();
        k = 0;
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_err++; $display("FAIL restart_ready got %b want 1", pix_if.pix_ready); end
        step();
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL restart_frame_start got %b want 1", frame_start); end
        for (int i = 1; i <= 48; i++) begin
            if (i == 5)  enable = 1'b0;
            if (i == 10) enable = 1'b1;
            if (i == 48) pix_if.pix_valid = 1'b0;
            step();
            n_cmp++; if (frame_start !== (i == 48)) begin
                n_err++; $display("FAIL b2b_frame_start i=%0d got %b want %b", i, frame_start, i == 48);
            end
        end
        pix_if.pix_valid = 1'b1;
        n_cmp++; if ({data_en, underflow} !== 2'b11) begin n_err++; $display("FAIL b2b_uf got %b want 11", {data_en, underflow}); end
    endtask

    task automatic test_reset_midframe();
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_before got %b want 1", pix_if.pix_ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({frame_start, data_en, underflow, pix_if.pix_ready} !== 4'b0000) begin
            n_err++; $display("FAIL mid_reset_flags got %b want 0000", {frame_start, data_en, underflow, pix_if.pix_ready});
        end
        n_cmp++; if ({ctrl_0, ctrl_1} !== 2'b11) begin n_err++; $display("FAIL mid_reset_sync got %b want 11", {ctrl_0, ctrl_1}); end
        n_cmp++; if ({red, green, blue} !== 24'h0) begin n_err++; $display("FAIL mid_reset_rgb got %h want 000000", {red, green, blue}); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL mid_hold_ready got %b want 0", pix_if.pix_ready); end
        rst_n = 1'b1;
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_err++; $display("FAIL mid_release_ready got %b want 0", pix_if.pix_ready); end
        step();
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_err++; $display("FAIL mid_first_ready got %b want 1", pix_if.pix_ready); end
        step();
        n_cmp++; if ({frame_start, data_en} !== 2'b11) begin n_err++; $display("FAIL mid_first_frame got %b want 11", {frame_start, data_en}); end
        n_cmp++; if ({red, green, blue} !== PIX) begin n_err++; $display("FAIL mid_first_rgb got %h want %h", {red, green, blue}, PIX); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underflow();
        test_stop();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
